// File: rtl/mem_access_pkg.sv
// Shared definitions for the Eriscv memory-access stage: ALU op encodings for
// loads/stores, FSM state codes and a memory-op classifier.
package mem_access_pkg;

   localparam int ALUOP_W = 8;

   typedef logic [ALUOP_W-1:0] AluOpBus;

   localparam AluOpBus EXE_NOP_OP = 8'h00;
   localparam AluOpBus EXE_LB_OP  = 8'hE0;
   localparam AluOpBus EXE_LH_OP  = 8'hE1;
   localparam AluOpBus EXE_LW_OP  = 8'hE3;
   localparam AluOpBus EXE_LBU_OP = 8'hE4;
   localparam AluOpBus EXE_LHU_OP = 8'hE5;
   localparam AluOpBus EXE_SB_OP  = 8'hE8;
   localparam AluOpBus EXE_SH_OP  = 8'hE9;
   localparam AluOpBus EXE_SW_OP  = 8'hEB;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } mem_state_t;

   function automatic logic is_mem_op(input AluOpBus op);
      case (op)
         EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
         EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
         default:                         is_mem_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: store byte enables and replication, load lane
// extraction with sign/zero extension, and the misalignment flag.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [ALUOP_W-1:0] i_aluop,
   input  logic [1:0]         i_addr_lo,
   input  logic [31:0]        i_st_data,
   input  logic [31:0]        i_ld_data,
   output logic               o_is_mem,
   output logic               o_is_load,
   output logic               o_misalign,
   output logic [3:0]         o_be,
   output logic [31:0]        o_st_data,
   output logic [31:0]        o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte   = i_ld_data[{i_addr_lo, 3'b000} +: 8];
   assign w_half   = i_ld_data[{i_addr_lo[1], 4'b0000} +: 16];
   assign o_is_mem = is_mem_op(i_aluop);

   // Per-op lane selection; loads always fetch the full word
   always_comb begin
      o_is_load  = 1'b0;
      o_misalign = 1'b0;
      o_be       = 4'b1111;
      o_st_data  = i_st_data;
      o_ld_data  = i_ld_data;
      case (i_aluop)
         EXE_LB_OP: begin
            o_is_load = 1'b1;
            o_ld_data = {{24{w_byte[7]}}, w_byte};
         end
         EXE_LBU_OP: begin
            o_is_load = 1'b1;
            o_ld_data = {24'd0, w_byte};
         end
         EXE_LH_OP: begin
            o_is_load  = 1'b1;
            o_misalign = i_addr_lo[0];
            o_ld_data  = {{16{w_half[15]}}, w_half};
         end
         EXE_LHU_OP: begin
            o_is_load  = 1'b1;
            o_misalign = i_addr_lo[0];
            o_ld_data  = {16'd0, w_half};
         end
         EXE_LW_OP: begin
            o_is_load  = 1'b1;
            o_misalign = |i_addr_lo;
         end
         EXE_SB_OP: begin
            o_be      = 4'b0001 << i_addr_lo;
            o_st_data = {4{i_st_data[7:0]}};
         end
         EXE_SH_OP: begin
            o_misalign = i_addr_lo[0];
            o_be       = 4'b0011 << i_addr_lo;
            o_st_data  = {2{i_st_data[15:0]}};
         end
         EXE_SW_OP: begin
            o_misalign = |i_addr_lo;
         end
         default: begin
            o_is_load = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues aligned loads/stores on a req/ack bus,
// stalls upstream while a transaction is outstanding, registers write-back.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [31:0]        mem_addr_i,
   input  logic [31:0]        rt_data_i,
   input  logic [4:0]         reg_waddr_i,
   input  logic               reg_we_i,
   input  logic [31:0]        reg_wdata_i,
   output logic               stall_req_o,
   output logic [4:0]         reg_waddr_o,
   output logic               reg_we_o,
   output logic [31:0]        reg_wdata_o,
   output logic               exc_misalign_o,
   output logic               bus_err_o,
   output logic               dbus_req_o,
   output logic               dbus_we_o,
   output logic [31:0]        dbus_addr_o,
   output logic [3:0]         dbus_be_o,
   output logic [31:0]        dbus_wdata_o,
   input  logic [31:0]        dbus_rdata_i,
   input  logic               dbus_ack_i
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   mem_state_t  r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [4:0]  r_waddr, w_waddr_nxt;
   logic        r_we, w_we_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;
   logic        r_exc, w_exc_nxt;
   logic        r_err, w_err_nxt;
   logic        r_req, w_req_nxt;
   logic        r_dwe, w_dwe_nxt;
   logic [31:0] r_daddr, w_daddr_nxt;
   logic [3:0]  r_be, w_be_nxt;
   logic [31:0] r_dwdata, w_dwdata_nxt;
   logic        w_stall, w_is_mem, w_is_load, w_misalign, w_timeout;
   logic [3:0]  w_be;
   logic [31:0] w_st_data, w_ld_data;

   mem_align u_align (
      .i_aluop    (aluop_i),
      .i_addr_lo  (mem_addr_i[1:0]),
      .i_st_data  (rt_data_i),
      .i_ld_data  (dbus_rdata_i),
      .o_is_mem   (w_is_mem),
      .o_is_load  (w_is_load),
      .o_misalign (w_misalign),
      .o_be       (w_be),
      .o_st_data  (w_st_data),
      .o_ld_data  (w_ld_data)
   );

   // The BUS cycle counter starts at 0, so TIMEOUT-1 is the last cycle the request is held
   assign w_timeout = (r_cnt == TO_LAST);

   // Next-state and next-output decode; upstream inputs are held while stalled
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_waddr_nxt  = r_waddr;
      w_we_nxt     = 1'b0;
      w_wdata_nxt  = r_wdata;
      w_exc_nxt    = 1'b0;
      w_err_nxt    = 1'b0;
      w_req_nxt    = r_req;
      w_dwe_nxt    = r_dwe;
      w_daddr_nxt  = r_daddr;
      w_be_nxt     = r_be;
      w_dwdata_nxt = r_dwdata;
      w_stall      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (valid_i && !w_is_mem) begin
               w_we_nxt    = reg_we_i;
               w_waddr_nxt = reg_waddr_i;
               w_wdata_nxt = reg_wdata_i;
            end else if (valid_i && w_misalign) begin
               w_exc_nxt = 1'b1;
            end else if (valid_i) begin
               w_stall      = 1'b1;
               w_state_nxt  = ST_BUS;
               w_cnt_nxt    = 8'd0;
               w_req_nxt    = 1'b1;
               w_dwe_nxt    = ~w_is_load;
               w_daddr_nxt  = {mem_addr_i[31:2], 2'b00};
               w_be_nxt     = w_be;
               w_dwdata_nxt = w_st_data;
            end else begin
               w_we_nxt = 1'b0;
            end
         end
         ST_BUS: begin
            if (dbus_ack_i) begin
               w_state_nxt = ST_IDLE;
               w_req_nxt   = 1'b0;
               w_dwe_nxt   = 1'b0;
               w_we_nxt    = w_is_load & reg_we_i;
               if (w_is_load) begin
                  w_waddr_nxt = reg_waddr_i;
                  w_wdata_nxt = w_ld_data;
               end else begin
                  w_wdata_nxt = r_wdata;
               end
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_req_nxt   = 1'b0;
               w_dwe_nxt   = 1'b0;
               w_err_nxt   = 1'b1;
            end else begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
            w_dwe_nxt   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset discards any transaction in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_waddr  <= 5'd0;
         r_we     <= 1'b0;
         r_wdata  <= 32'd0;
         r_exc    <= 1'b0;
         r_err    <= 1'b0;
         r_req    <= 1'b0;
         r_dwe    <= 1'b0;
         r_daddr  <= 32'd0;
         r_be     <= 4'd0;
         r_dwdata <= 32'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_waddr  <= w_waddr_nxt;
         r_we     <= w_we_nxt;
         r_wdata  <= w_wdata_nxt;
         r_exc    <= w_exc_nxt;
         r_err    <= w_err_nxt;
         r_req    <= w_req_nxt;
         r_dwe    <= w_dwe_nxt;
         r_daddr  <= w_daddr_nxt;
         r_be     <= w_be_nxt;
         r_dwdata <= w_dwdata_nxt;
      end
   end

   assign stall_req_o    = w_stall;
   assign reg_waddr_o    = r_waddr;
   assign reg_we_o       = r_we;
   assign reg_wdata_o    = r_wdata;
   assign exc_misalign_o = r_exc;
   assign bus_err_o      = r_err;
   assign dbus_req_o     = r_req;
   assign dbus_we_o      = r_dwe;
   assign dbus_addr_o    = r_daddr;
   assign dbus_be_o      = r_be;
   assign dbus_wdata_o   = r_dwdata;

endmodule

// File: tb/tb_mem_access.sv
// Randomized scoreboard bench for mem_access: a driver issues ops and plays the
// bus slave; monitors pop expected bus requests and write-back events.
module tb_mem_access;
   import mem_access_pkg::*;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [7:0]  aluop_i;
   logic [31:0] mem_addr_i, rt_data_i, reg_wdata_i, dbus_rdata_i;
   logic [4:0]  reg_waddr_i;
   logic        reg_we_i, dbus_ack_i;
   logic        stall_req_o, reg_we_o, exc_misalign_o, bus_err_o, dbus_req_o, dbus_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o, dbus_addr_o, dbus_wdata_o;
   logic [3:0]  dbus_be_o;

   mem_access #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i),
      .mem_addr_i(mem_addr_i), .rt_data_i(rt_data_i), .reg_waddr_i(reg_waddr_i),
      .reg_we_i(reg_we_i), .reg_wdata_i(reg_wdata_i), .stall_req_o(stall_req_o),
      .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o), .reg_wdata_o(reg_wdata_o),
      .exc_misalign_o(exc_misalign_o), .bus_err_o(bus_err_o), .dbus_req_o(dbus_req_o),
      .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
      .dbus_wdata_o(dbus_wdata_o), .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
   );

   always #5 clk = ~clk;

   // kind is one-hot {bus_err, misalign, write-back}
   typedef struct { logic [2:0] kind; logic [4:0] waddr; logic [31:0] wdata; } wb_t;
   typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic chk_wd; } bus_t;

   wb_t  wb_q[$];
   bus_t bus_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int op_size(input logic [7:0] op);
      if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
      if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
      return 4;
   endfunction

   function automatic bit ref_is_load(input logic [7:0] op);
      return op == EXE_LB_OP || op == EXE_LH_OP || op == EXE_LW_OP ||
             op == EXE_LBU_OP || op == EXE_LHU_OP;
   endfunction

   function automatic logic [31:0] ld_ref(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      logic [31:0] v;
      v = rdata >> (8 * (addr % 4));
      if (op == EXE_LB_OP || op == EXE_LBU_OP) v = v & 32'hFF;
      if (op == EXE_LH_OP || op == EXE_LHU_OP) v = v & 32'hFFFF;
      if (op == EXE_LB_OP && v >= 32'd128)   v = v - 32'd256;
      if (op == EXE_LH_OP && v >= 32'd32768) v = v - 32'd65536;
      return v;
   endfunction

   function automatic logic [3:0] be_ref(input logic [7:0] op, input logic [31:0] addr);
      logic [3:0] be;
      int lane, sz;
      lane = int'(addr % 4);
      sz   = ref_is_load(op) ? 4 : op_size(op);
      be   = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (ref_is_load(op) || (i >= lane && i < lane + sz)) be[i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] st_ref(input logic [7:0] op, input logic [31:0] data);
      if (op == EXE_SB_OP) return (data & 32'hFF) * 32'h0101_0101;
      if (op == EXE_SH_OP) return (data & 32'hFFFF) * 32'h0001_0001;
      return data;
   endfunction

   // Issue one op, act as bus slave, count stall cycles against the model
   task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wa, input logic we, input int nwait,
                        input logic [31:0] rdata, input bit no_ack);
      int   sz, cyc, stalls, exp_stall;
      bit   mem, load, aligned, st;
      bus_t b;
      wb_t  w;
      mem       = is_mem_op(op);
      load      = ref_is_load(op);
      sz        = op_size(op);
      aligned   = ((addr % sz) == 0);
      exp_stall = 0;
      w.waddr   = wa;
      w.wdata   = 32'd0;
      if (!mem) begin
         if (we) begin
            w.kind = 3'b001; w.wdata = ~data; wb_q.push_back(w);
         end
      end else if (!aligned) begin
         w.kind = 3'b010; wb_q.push_back(w);
      end else begin
         b.we = !load; b.addr = addr - (addr % 4); b.be = be_ref(op, addr);
         b.wdata = st_ref(op, data); b.chk_wd = !load;
         bus_q.push_back(b);
         if (no_ack) begin
            w.kind = 3'b100; wb_q.push_back(w); exp_stall = TMO;
         end else begin
            exp_stall = nwait + 1;
            if (load && we) begin
               w.kind = 3'b001; w.wdata = ld_ref(op, addr, rdata); wb_q.push_back(w);
            end
         end
      end
      valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; rt_data_i = data;
      reg_wdata_i = ~data; reg_waddr_i = wa; reg_we_i = we;
      cyc = 0; stalls = 0;
      forever begin
         dbus_ack_i   = mem && aligned && !no_ack && (cyc == nwait + 1);
         dbus_rdata_i = dbus_ack_i ? rdata : $urandom;
         @(negedge clk);
         st = stall_req_o;
         if (st) stalls++;
         @(posedge clk); #1;
         cyc++;
         if (!st) break;
         if (cyc > 300) begin
            tests++; fails++;
            $display("FAIL stall_bound: stall high for %0d cycles, expected release", cyc);
            break;
         end
      end
      dbus_ack_i = 1'b0;
      valid_i    = 1'b0;
      check("stall_cycles", stalls, exp_stall);
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk_zero(input string tag);
      check({tag, "_ctl"}, {18'd0, dbus_be_o, reg_waddr_o, dbus_req_o, dbus_we_o,
                            reg_we_o, exc_misalign_o, bus_err_o}, 32'd0);
      check({tag, "_wdata"}, reg_wdata_o, 32'd0);
      check({tag, "_daddr"}, dbus_addr_o, 32'd0);
      check({tag, "_dwdata"}, dbus_wdata_o, 32'd0);
   endtask

   // Write-back monitor
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (rst && (reg_we_o || exc_misalign_o || bus_err_o)) begin
            if (wb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL wb_unexpected: got event %b, expected none", {bus_err_o, exc_misalign_o, reg_we_o});
            end else begin
               e = wb_q.pop_front();
               check("wb_kind", {29'd0, bus_err_o, exc_misalign_o, reg_we_o}, {29'd0, e.kind});
               if (e.kind == 3'b001) begin
                  check("wb_addr", {27'd0, reg_waddr_o}, {27'd0, e.waddr});
                  check("wb_data", reg_wdata_o, e.wdata);
               end
            end
         end
      end
   end

   // Bus monitor: new request pops an expectation, held request must stay stable
   initial begin
      bus_t cur;
      logic prev_req;
      prev_req = 1'b0;
      cur = '{1'b0, 32'd0, 4'd0, 32'd0, 1'b0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_req = 1'b0;
         end else begin
            if (dbus_req_o && !prev_req) begin
               if (bus_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL bus_unexpected: got request at 0x%08h, expected none", dbus_addr_o);
               end else begin
                  cur = bus_q.pop_front();
               end
            end
            if (dbus_req_o) begin
               check("bus_we", {31'd0, dbus_we_o}, {31'd0, cur.we});
               check("bus_addr", dbus_addr_o, cur.addr);
               check("bus_be", {28'd0, dbus_be_o}, {28'd0, cur.be});
               if (cur.chk_wd) check("bus_wdata", dbus_wdata_o, cur.wdata);
            end
            prev_req = dbus_req_o;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  op;
      logic [31:0] addr;
      logic [7:0]  ops [8];
      ops = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
      rst = 1'b0; valid_i = 1'b0; aluop_i = EXE_NOP_OP; mem_addr_i = 32'd0; rt_data_i = 32'd0;
      reg_wdata_i = 32'd0; reg_waddr_i = 5'd0; reg_we_i = 1'b0; dbus_rdata_i = 32'd0; dbus_ack_i = 1'b0;
      #12;
      chk_zero("reset");
      @(posedge clk); #1;
      rst = 1'b1;

      do_op(EXE_SW_OP,  32'h100, 32'h1234_5678, 5'd3, 1'b1, 3, 32'd0, 1'b0);
      do_op(EXE_LB_OP,  32'h103, 32'h0,         5'd4, 1'b1, 0, 32'h8000_0000, 1'b0);
      do_op(EXE_LHU_OP, 32'h102, 32'h0,         5'd5, 1'b1, 1, 32'hBEEF_0000, 1'b0);
      do_op(EXE_SB_OP,  32'h101, 32'h0000_00AB, 5'd6, 1'b1, 2, 32'd0, 1'b0);
      do_op(EXE_LW_OP,  32'h102, 32'h0,         5'd7, 1'b1, 0, 32'd0, 1'b0);
      do_op(EXE_LW_OP,  32'h200, 32'h0,         5'd8, 1'b1, 0, 32'd0, 1'b1);
      do_op(EXE_LH_OP,  32'h206, 32'h0,         5'd9, 1'b1, TMO - 1, 32'h9ABC_1234, 1'b0);
      do_op(8'h21,      32'h0,   32'h5555_AAAA, 5'd10, 1'b1, 0, 32'd0, 1'b0);

      // reset in the middle of a bus transaction
      bus_q.push_back('{1'b0, 32'h40, 4'hF, 32'd0, 1'b0});
      valid_i = 1'b1; aluop_i = EXE_LW_OP; mem_addr_i = 32'h40; reg_we_i = 1'b1; reg_waddr_i = 5'd11;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_zero("rst_mid_bus");
      valid_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      do_op(EXE_LW_OP, 32'h300, 32'h0, 5'd12, 1'b1, 1, 32'hCAFE_F00D, 1'b0);

      for (int i = 0; i < 150; i++) begin
         int k;
         k = $urandom_range(0, 9);
         if (k == 9) begin
            idle($urandom_range(1, 2));
         end else begin
            if (k == 8) begin
               do op = 8'($urandom); while (is_mem_op(op));
            end else begin
               op = ops[k];
            end
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % op_size(op));
            do_op(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom_range(0, TMO - 1),
                  $urandom, ($urandom_range(0, 11) == 0));
         end
      end

      idle(4);
      check("wb_q_empty", wb_q.size(), 32'd0);
      check("bus_q_empty", bus_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the Eriscv pipeline, directly downstream of `ex`. Consumes the execute result and the load/store fields produced by `ex` (`aluop`, `mem_addr`, `rt_data`) and runs load/store ops on a req/ack data bus through a small FSM. Aligns and sign-/zero-extends load data, generates store byte enables, raises a pipeline stall while a transaction is outstanding, and registers the write-back result for `mem_wb`.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum BUS-state cycles without `dbus_ack_i` before abort; 2..255.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  upstream holds a valid instruction.
- `aluop_i`  in  `AluOpBus`  op from `ex`; load/store ops select bus activity.
- `mem_addr_i`  in  32  byte address from `ex`.
- `rt_data_i`  in  32  store data from `ex`.
- `reg_waddr_i`  in  5  destination register.
- `reg_we_i`  in  1  write enable.
- `reg_wdata_i`  in  32  `ex` result, used by non-memory ops.
- `stall_req_o`  out  1  combinational; upstream holds all inputs while high.
- `reg_waddr_o`  out  5  registered write-back address.
- `reg_we_o`  out  1  registered write-back enable.
- `reg_wdata_o`  out  32  registered write-back data.
- `exc_misalign_o`  out  1  one-cycle registered pulse, misaligned access.
- `bus_err_o`  out  1  one-cycle registered pulse, bus timeout.
- `dbus_req_o`  out  1  registered request.
- `dbus_we_o`  out  1  1 = write.
- `dbus_addr_o`  out  32  word-aligned address, `{mem_addr_i[31:2],2'b00}`.
- `dbus_be_o`  out  4  byte lanes.
- `dbus_wdata_o`  out  32  lane-replicated store data.
- `dbus_rdata_i`  in  32  read data, valid when `dbus_ack_i` is high.
- `dbus_ack_i`  in  1  completes the transaction.

## Operation
- States: IDLE, BUS. All outputs reset to 0; state resets to IDLE.
- Non-memory op with `valid_i`: pass through `reg_*` to the registered outputs; no stall.
- `valid_i` low: `reg_we_o` is 0 on the next edge.
- Memory op: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Misalignment check: halfword ops require `addr[0]=0`; word ops require `addr[1:0]=0`.
- Misaligned access: no bus access, no stall, `exc_misalign_o` pulses, `reg_we_o` is 0.
- Aligned access from IDLE: `stall_req_o` is high. On the next edge, enter BUS with `dbus_req_o`, `dbus_we_o`, address, byte enables and data registered.
- BE values:
  - SB: `4'b0001 << addr[1:0]`.
  - SH: `4'b0011 << addr[1:0]`.
  - SW: `1111`.
  - Loads: `1111`.
- Store data: SB replicates the byte to all 4 lanes; SH replicates the halfword to both halves.
- BUS: request and all `dbus_*` fields stay stable until ack. Cycle counter increments each BUS cycle.
- Ack in BUS: at that edge, `dbus_req_o` drops, state returns to IDLE, and `reg_*` outputs are written.
  - Loads: `reg_we_o = reg_we_i`, data is the extracted lane.
  - Stores: `reg_we_o = 0`.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout: counter reaches `TIMEOUT` with no ack → drop request, return to IDLE, pulse `bus_err_o`, `reg_we_o = 0`.
- Ack and timeout in the same cycle: ack wins.
- `rst` asserted in any state: `dbus_req_o` drops immediately and asynchronously; transaction discarded, no write-back.

## Timing
- `stall_req_o = (IDLE & valid_i & aligned_mem_op) | (BUS & ~dbus_ack_i & ~timeout_hit)`.
- Upstream advances on the same edge that captures the result; no duplicate issue.
- Non-memory latency: 1 cycle.
- Memory latency: 1 (issue) + N wait cycles + 1 (ack cycle); result visible the cycle after ack.
  - Zero-wait ack gives 2 stall-free edges... precisely: stall is high for exactly N+1 cycles.
- Back-to-back memory ops: the next op may start in the cycle after ack; `dbus_req_o` is low for at least 1 cycle between transactions.

## Structure
- Add `EXE_LB_OP`, `EXE_LH_OP`, `EXE_LW_OP`, `EXE_LBU_OP`, `EXE_LHU_OP`, `EXE_SB_OP`, `EXE_SH_OP`, `EXE_SW_OP` to `defines.v`, in `AluOpBus` encoding.
- Add FSM state codes to `defines.v`.
- One combinational sub-module, `mem_align`:
  - Store side: BE and lane replication.
  - Load side: lane extraction and extension.
  - Misalignment flag.

## Test plan
- SW, addr `0x100`, data `0x12345678`, ack after 3 wait cycles → BE `1111`, wdata `0x12345678`, stall 4 cycles, `reg_we_o = 0`.
- LB, addr `0x103`, rdata `0x80000000`, zero-wait ack → `reg_wdata_o = 0xFFFFFF80`, one cycle after ack.
- LHU, addr `0x102`, rdata `0xBEEF0000` → `0x0000BEEF`. SB, addr `0x101`, data `0xAB` → BE `0010`, wdata `0xABABABAB`.
- LW, addr `0x102` → `exc_misalign_o` pulse, `dbus_req_o` never high, no stall, `reg_we_o = 0`.
- `TIMEOUT = 8`, no ack → request held 8 cycles, then `bus_err_o` pulse, IDLE, stall released.
- `rst` low mid-BUS → `dbus_req_o = 0` immediately, all outputs 0. After release, a new LW completes normally.
